// File: rtl/serial_deframer.sv
// Receive-side deframer for the slave serial link: hunts a sync nibble in an
// LSB-first bit stream, reassembles data nibbles and checks a per-frame XOR checksum.
module serial_deframer #(
  parameter logic [3:0] SYNC          = 4'hA,
  parameter int         FRAME_NIBBLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic [3:0] dout,
  output logic       dvalid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       locked,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CSUM  = 2'd2,
    VSYNC = 2'd3
  } state_t;

  localparam logic [3:0] LAST_NIB = 4'(FRAME_NIBBLES - 1);

  function automatic logic [3:0] csum_update(input logic [3:0] acc, input logic [3:0] nib);
    csum_update = acc ^ nib;
  endfunction

  state_t     r_state;
  logic [3:0] r_sh;
  logic [1:0] r_bitcnt;
  logic [3:0] r_nibcnt;
  logic [3:0] r_csum;
  logic [3:0] r_dout;
  logic       r_dvalid;
  logic       r_frame_ok;
  logic       r_frame_err;
  logic       r_locked;
  logic       r_lock_lost;

  state_t     w_state_nxt;
  logic [3:0] w_nw;
  logic       w_last_bit;
  logic [1:0] w_bitcnt_nxt;
  logic [3:0] w_nibcnt_nxt;
  logic [3:0] w_csum_nxt;
  logic [3:0] w_dout_nxt;
  logic       w_dvalid_nxt;
  logic       w_frame_ok_nxt;
  logic       w_frame_err_nxt;
  logic       w_locked_nxt;
  logic       w_lock_lost_nxt;

  // Newest four bits with the first-received bit in position 0.
  assign w_nw       = {sin, r_sh[3:1]};
  assign w_last_bit = (r_bitcnt == 2'd3);

  // Next-state and next-output logic; pulses default low every edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_bitcnt_nxt    = r_bitcnt;
    w_nibcnt_nxt    = r_nibcnt;
    w_csum_nxt      = r_csum;
    w_dout_nxt      = r_dout;
    w_dvalid_nxt    = 1'b0;
    w_frame_ok_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_locked_nxt    = r_locked;
    w_lock_lost_nxt = 1'b0;

    case (r_state)
      HUNT: begin
        if (w_nw == SYNC) begin
          w_locked_nxt = 1'b1;
          w_bitcnt_nxt = 2'd0;
          w_nibcnt_nxt = 4'd0;
          w_csum_nxt   = 4'd0;
          w_state_nxt  = DATA;
        end else begin
          w_state_nxt = HUNT;
        end
      end

      DATA: begin
        w_bitcnt_nxt = r_bitcnt + 2'd1;
        if (w_last_bit) begin
          w_dout_nxt   = w_nw;
          w_dvalid_nxt = 1'b1;
          w_csum_nxt   = csum_update(r_csum, w_nw);
          w_nibcnt_nxt = r_nibcnt + 4'd1;
          if (r_nibcnt == LAST_NIB) begin
            w_state_nxt = CSUM;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end

      CSUM: begin
        w_bitcnt_nxt = r_bitcnt + 2'd1;
        if (w_last_bit) begin
          if (w_nw == r_csum) begin
            w_frame_ok_nxt = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
          w_state_nxt = VSYNC;
        end else begin
          w_state_nxt = CSUM;
        end
      end

      VSYNC: begin
        w_bitcnt_nxt = r_bitcnt + 2'd1;
        if (w_last_bit) begin
          if (w_nw == SYNC) begin
            w_csum_nxt   = 4'd0;
            w_nibcnt_nxt = 4'd0;
            w_state_nxt  = DATA;
          end else begin
            // Frames are back-to-back; a missing sync means alignment is gone.
            w_locked_nxt    = 1'b0;
            w_lock_lost_nxt = 1'b1;
            w_state_nxt     = HUNT;
          end
        end else begin
          w_state_nxt = VSYNC;
        end
      end

      default: begin
        w_state_nxt  = HUNT;
        w_locked_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_sh        <= 4'd0;
      r_bitcnt    <= 2'd0;
      r_nibcnt    <= 4'd0;
      r_csum      <= 4'd0;
      r_dout      <= 4'd0;
      r_dvalid    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_nw;
      r_bitcnt    <= w_bitcnt_nxt;
      r_nibcnt    <= w_nibcnt_nxt;
      r_csum      <= w_csum_nxt;
      r_dout      <= w_dout_nxt;
      r_dvalid    <= w_dvalid_nxt;
      r_frame_ok  <= w_frame_ok_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_locked    <= w_locked_nxt;
      r_lock_lost <= w_lock_lost_nxt;
    end
  end

  assign dout      = r_dout;
  assign dvalid    = r_dvalid;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign locked    = r_locked;
  assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_serial_deframer.sv
// Scoreboard bench for serial_deframer: stimulus queues expected pulses,
// a negedge monitor pops and compares them, including the exact cycle.
module tb_serial_deframer;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic [3:0] dout;
  logic       dvalid;
  logic       frame_ok;
  logic       frame_err;
  logic       locked;
  logic       lock_lost;

  serial_deframer #(.SYNC(4'hA), .FRAME_NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .dout      (dout),
    .dvalid    (dvalid),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .locked    (locked),
    .lock_lost (lock_lost)
  );

  localparam logic [1:0] EV_DV = 2'd0, EV_OK = 2'd1, EV_ERR = 2'd2, EV_LOST = 2'd3;

  typedef struct {
    logic [1:0] kind;
    logic [3:0] data;
    int         cyc;
  } ev_t;

  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   npulse;
  logic [1:0] mkind;
  ev_t  mev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every observed pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    npulse = int'(dvalid) + int'(frame_ok) + int'(frame_err) + int'(lock_lost);
    if (npulse > 1) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL simultaneous_pulses: got %0d pulses at cycle %0d, required at most 1", npulse, cyc);
    end else if (npulse == 1) begin
      mkind = dvalid ? EV_DV : (frame_ok ? EV_OK : (frame_err ? EV_ERR : EV_LOST));
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_pulse: got kind %0d dout %h at cycle %0d, required no pulse", mkind, dout, cyc);
      end else begin
        mev = sb.pop_front();
        if (mev.kind != mkind || (mkind == EV_DV && mev.data != dout) || cyc != mev.cyc + 1) begin
          errors = errors + 1;
          $display("FAIL pulse: got kind %0d dout %h cycle %0d, required kind %0d dout %h cycle %0d",
                   mkind, dout, cyc, mev.kind, mev.data, mev.cyc + 1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int i = 0; i < 4; i++) send_bit(n[i]);
  endtask

  task automatic send_data(input logic [3:0] n);
    send_nib(n);
    push(EV_DV, n);
  endtask

  // Samples locked just after the edge that consumes the most recent bit.
  task automatic chk_locked(input string name, input logic exp);
    @(posedge clk);
    #1;
    chk(name, {15'd0, locked}, {15'd0, exp});
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sin = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sin   = 1'b0;
  endtask

  logic [3:0] garbage;

  initial begin
    rst_n   = 1'b0;
    sin     = 1'b0;
    garbage = 4'b0111;

    // Reset with random input, then idle zeros.
    repeat (5) begin
      @(negedge clk);
      sin = 1'($urandom_range(0, 1));
    end
    chk("reset_outputs", {7'd0, dout, dvalid, frame_ok, frame_err, locked, lock_lost}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sin   = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_outputs", {7'd0, dout, dvalid, frame_ok, frame_err, locked, lock_lost}, 16'd0);

    // Good frame: A, 1,2,3,4, checksum 4.
    send_nib(4'hA);
    chk_locked("locked_after_sync", 1'b1);
    send_data(4'h1);
    send_data(4'h2);
    send_data(4'h3);
    send_data(4'h4);
    send_nib(4'h4);
    push(EV_OK, 4'h0);
    chk_locked("locked_after_good", 1'b1);

    // Bad checksum, then a good frame 5..8 (5^6^7^8 = C).
    send_nib(4'hA);
    send_data(4'h1);
    send_data(4'h2);
    send_data(4'h3);
    send_data(4'h4);
    send_nib(4'h5);
    push(EV_ERR, 4'h0);
    chk_locked("locked_after_bad", 1'b1);
    send_nib(4'hA);
    send_data(4'h5);
    send_data(4'h6);
    send_data(4'h7);
    send_data(4'h8);
    send_nib(4'hC);
    push(EV_OK, 4'h0);

    // Lock loss on sync 5, zero filler, relock only on the A.
    send_nib(4'h5);
    push(EV_LOST, 4'h0);
    chk_locked("unlocked_after_bad_sync", 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk_locked("no_early_relock", 1'b0);
    send_bit(1'b1);
    chk_locked("relock_on_sync", 1'b1);
    send_data(4'hF);
    send_data(4'h0);
    send_data(4'hF);
    send_data(4'h0);
    send_nib(4'h0);
    push(EV_OK, 4'h0);
    send_nib(4'h0);
    push(EV_LOST, 4'h0);
    chk_locked("unlocked_after_zero_sync", 1'b0);

    // Leading garbage 1,1,1,0,1,0,1 from a clean reset.
    do_reset();
    for (int i = 0; i < 4; i++) send_bit(garbage[i]);
    chk_locked("garbage_no_lock_4", 1'b0);
    send_bit(1'b1);
    chk_locked("garbage_no_lock_5", 1'b0);
    send_bit(1'b0);
    chk_locked("garbage_no_lock_6", 1'b0);
    send_bit(1'b1);
    chk_locked("garbage_lock_7", 1'b1);

    // Mid-frame reset after the second data nibble.
    do_reset();
    send_nib(4'hA);
    send_data(4'h1);
    send_data(4'h2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {7'd0, dout, dvalid, frame_ok, frame_err, locked, lock_lost}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_nib(4'h3);
    send_nib(4'h4);
    send_nib(4'h4);
    chk_locked("no_lock_after_reset", 1'b0);
    chk("dout_after_reset", {12'd0, dout}, 16'd0);
    send_nib(4'hA);
    send_data(4'h9);
    send_data(4'hA);
    send_data(4'hB);
    send_data(4'hC);
    send_nib(4'h4);
    push(EV_OK, 4'h0);
    chk_locked("relock_after_reset", 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion before 200000");
    $fatal(1);
  end

endmodule
